// File: rtl/arb_pkg.sv
// Shared constants, types and helpers for the request/grant arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a; the arbiter has no stall input, it re-arbitrates every cycle.
package arb_pkg;

  localparam int ARB_N_DEFAULT  = 2;
  localparam int ARB_RR_DEFAULT = 0;

  typedef enum logic {
    FIXED = 1'b0,
    RR    = 1'b1
  } arb_mode_e;

  // Width of a grant index. Clamped to 1 so a degenerate N never gives a zero-width bus.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_prio_if.sv
// Request/grant bundle between requesters and the arbiter.
// Latency: n/a (wires only).
// Backpressure: none; the request vector is re-sampled every cycle.
// Signals: request (requesters -> arbiter), grant / grant_valid / grant_idx (arbiter -> requesters).
// Modports: master = requester side, slave = arbiter side.
interface arb_prio_if import arb_pkg::*; #(
  parameter int N = ARB_N_DEFAULT
) ();

  localparam int IW = idx_w(N);

  logic [N-1:0]  request;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;

  modport master (
    output request,
    input  grant,
    input  grant_valid,
    input  grant_idx
  );

  modport slave (
    input  request,
    output grant,
    output grant_valid,
    output grant_idx
  );

endinterface

// File: rtl/arb_prio_enc.sv
// Rotating priority encoder: first set bit of i_req at or after i_start, wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: i_req (request vector), i_start (search start index),
//        o_onehot (winner one-hot), o_idx (winner index), o_found (any bit set).
module arb_prio_enc import arb_pkg::*; #(
  parameter int N  = ARB_N_DEFAULT,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  int            w_p;
  logic [IW-1:0] w_pos;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_found  = 1'b0;
    w_p      = 0;
    w_pos    = '0;
    for (int k = 0; k < N; k++) begin
      // Walk positions start, start+1, ... modulo N; the first hit wins and
      // later hits are ignored, which keeps the result one-hot.
      w_p = int'(i_start) + k;
      if (w_p >= N) w_p = w_p - N;
      w_pos = IW'(w_p);
      if (!o_found && i_req[w_pos]) begin
        o_found         = 1'b1;
        o_onehot[w_pos] = 1'b1;
        o_idx           = w_pos;
      end
    end
  end

endmodule

// File: rtl/arb_prio.sv
// Registered request/grant arbiter, fixed priority (index 0 first) or round-robin.
// Latency: 1 cycle from request sampled to grant driven; outputs come only from flops.
// Backpressure: none; a grant lasts one cycle and is re-arbitrated every edge.
// Ports: clk, reset (sync, active-high), arb (slave side of arb_prio_if:
//        request in; grant, grant_valid, grant_idx out).
module arb_prio import arb_pkg::*; #(
  parameter int N           = ARB_N_DEFAULT,
  parameter int ROUND_ROBIN = ARB_RR_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  arb_prio_if.slave  arb
);

  localparam int        IW   = idx_w(N);
  localparam arb_mode_e MODE = (ROUND_ROBIN != 0) ? RR : FIXED;

  logic [N-1:0]  r_grant;
  logic          r_grant_valid;
  logic [IW-1:0] r_grant_idx;
  logic [IW-1:0] r_ptr;

  logic [IW-1:0] w_start;
  logic [N-1:0]  w_onehot;
  logic [IW-1:0] w_idx;
  logic          w_found;

  // Round-robin searches from the slot after the last winner; the pointer
  // resets to N-1 so requester 0 is first in line after reset.
  always_comb begin
    w_start = '0;
    if (MODE == RR) begin
      w_start = (r_ptr == IW'(N - 1)) ? '0 : r_ptr + IW'(1);
    end
  end

  arb_prio_enc #(
    .N  (N),
    .IW (IW)
  ) u_enc (
    .i_req    (arb.request),
    .i_start  (w_start),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_found  (w_found)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_idx   <= '0;
      r_ptr         <= IW'(N - 1);
    end else begin
      r_grant       <= w_onehot;
      r_grant_valid <= w_found;
      r_grant_idx   <= w_idx;
      // Idle cycles leave the pointer alone so fairness resumes where it stopped.
      if (w_found) r_ptr <= w_idx;
    end
  end

  assign arb.grant       = r_grant;
  assign arb.grant_valid = r_grant_valid;
  assign arb.grant_idx   = r_grant_idx;

endmodule

// File: tb/tb_arb_prio.sv
// Bench for arb_prio: a fixed-priority N=2 instance and a round-robin N=4 instance
// driven side by side from a vector table, hand sequences and random cycles.
// Expected values come from the table constants and from a bit-arithmetic reference model.
module tb_arb_prio;

  logic clk;
  logic reset;

  int checks;
  int failures;

  arb_prio_if #(.N(2)) bf ();
  arb_prio_if #(.N(4)) br ();

  arb_prio #(.N(2), .ROUND_ROBIN(0)) u_fix (.clk(clk), .reset(reset), .arb(bf.slave));
  arb_prio #(.N(4), .ROUND_ROBIN(1)) u_rr  (.clk(clk), .reset(reset), .arb(br.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [1:0] mg_f;
  logic [3:0] mg_r;
  int         mptr;

  typedef struct {
    logic       rst;
    logic [1:0] req_f;
    logic [1:0] exp_f;
    logic [3:0] req_r;
    logic [3:0] exp_r;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin pick: rotate so the search start is bit 0, isolate the lowest
  // set bit with two's complement, then rotate the index back.
  function automatic logic [3:0] rr_pick(input logic [3:0] req, input int start);
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [3:0] low;
    int         b;
    dbl = {req, req};
    rot = 4'(dbl >> start);
    low = rot & 4'(~rot + 4'd1);
    if (low == 4'd0) return 4'd0;
    b = $clog2(low);
    return 4'(1 << ((b + start) % 4));
  endfunction

  // One clock: drive at the falling edge, model at the rising edge, check at the next falling edge.
  task automatic cycle(input logic rst_v, input logic [1:0] rf, input logic [3:0] rr);
    reset      = rst_v;
    bf.request = rf;
    br.request = rr;
    @(posedge clk);
    if (rst_v) begin
      mg_f = 2'd0;
      mg_r = 4'd0;
      mptr = 3;
    end else begin
      mg_f = rf & 2'(~rf + 2'd1);
      mg_r = rr_pick(rr, (mptr + 1) % 4);
      if (mg_r != 4'd0) mptr = $clog2(mg_r);
    end
    @(negedge clk);
    chk("fix_grant", 32'(bf.grant), 32'(mg_f));
    chk("fix_valid", 32'(bf.grant_valid), 32'(|mg_f));
    chk("fix_idx",   32'(bf.grant_idx), 32'($clog2(mg_f)));
    chk("rr_grant",  32'(br.grant), 32'(mg_r));
    chk("rr_valid",  32'(br.grant_valid), 32'(|mg_r));
    chk("rr_idx",    32'(br.grant_idx), 32'($clog2(mg_r)));
    // Structural invariants, independent of the model
    chk("fix_onehot0", 32'($onehot0(bf.grant)), 32'd1);
    chk("rr_onehot0",  32'($onehot0(br.grant)), 32'd1);
    chk("rr_valid_or", 32'(br.grant_valid), 32'(|br.grant));
    chk("rr_idx_match", 32'(br.grant_idx), 32'($clog2(br.grant)));
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    mg_f       = '0;
    mg_r       = '0;
    mptr       = 3;
    reset      = 1'b1;
    bf.request = '0;
    br.request = '0;

    //          rst   req_f  exp_f  req_r    exp_r
    vecs[0]  = '{1'b1, 2'b00, 2'b00, 4'b1111, 4'b0000};
    vecs[1]  = '{1'b1, 2'b00, 2'b00, 4'b1111, 4'b0000};
    vecs[2]  = '{1'b0, 2'b01, 2'b01, 4'b1111, 4'b0001};
    vecs[3]  = '{1'b0, 2'b00, 2'b00, 4'b1111, 4'b0010};
    vecs[4]  = '{1'b0, 2'b11, 2'b01, 4'b1111, 4'b0100};
    vecs[5]  = '{1'b0, 2'b11, 2'b01, 4'b1111, 4'b1000};
    vecs[6]  = '{1'b0, 2'b11, 2'b01, 4'b1111, 4'b0001};
    vecs[7]  = '{1'b0, 2'b11, 2'b01, 4'b1010, 4'b0010};
    vecs[8]  = '{1'b0, 2'b10, 2'b10, 4'b1010, 4'b1000};
    vecs[9]  = '{1'b0, 2'b10, 2'b10, 4'b1010, 4'b0010};
    vecs[10] = '{1'b1, 2'b10, 2'b00, 4'b1010, 4'b0000};
    vecs[11] = '{1'b0, 2'b10, 2'b10, 4'b1010, 4'b0010};
    vecs[12] = '{1'b0, 2'b00, 2'b00, 4'b1111, 4'b0100};

    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].rst, vecs[i].req_f, vecs[i].req_r);
      chk("tbl_fix_grant", 32'(bf.grant), 32'(vecs[i].exp_f));
      chk("tbl_rr_grant",  32'(br.grant), 32'(vecs[i].exp_r));
      chk("tbl_fix_idx",   32'(bf.grant_idx), 32'(vecs[i].exp_f == 2'b10));
    end

    // Idle for 10 cycles: nothing granted, round-robin pointer must hold.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 2'b00, 4'b0000);
      chk("idle_fix_valid", 32'(bf.grant_valid), 32'd0);
      chk("idle_rr_valid",  32'(br.grant_valid), 32'd0);
    end
    // Last winner was index 2, so all-requesting continues at index 3.
    cycle(1'b0, 2'b11, 4'b1111);
    chk("idle_resume_rr", 32'(br.grant), 32'b1000);
    cycle(1'b0, 2'b11, 4'b1111);
    chk("idle_resume_rr2", 32'(br.grant), 32'b0001);

    // Deassertion: grant moves away on the edge after the request drops.
    cycle(1'b0, 2'b10, 4'b0100);
    chk("move_fix", 32'(bf.grant), 32'b10);
    chk("move_rr",  32'(br.grant), 32'b0100);
    cycle(1'b0, 2'b00, 4'b0000);
    chk("drop_fix", 32'(bf.grant), 32'b00);
    chk("drop_rr",  32'(br.grant), 32'b0000);

    // Random traffic with occasional mid-stream resets
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 19) == 0), 2'($urandom), 4'($urandom));
    end

    reset = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
